// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The queue entry pairs a fetched instruction word with the PC+4 of its fetch address.
package fetch_pkg;

  localparam int          FQ_DEPTH  = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fq_entry_t;

  // Instruction fetches are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Register array for the fetch queue.
// One synchronous write port and one asynchronous read port, both addressed by pointers.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic            CLOCK_IN,
  input  logic            i_we,
  input  logic [PW-1:0]   i_waddr,
  input  fq_entry_t       i_wdata,
  input  logic [PW-1:0]   i_raddr,
  output fq_entry_t       o_rdata
);

  fq_entry_t r_mem [DEPTH];

  // No reset: entries are only observed through the occupancy-masked read path.
  always_ff @(posedge CLOCK_IN) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front-end: owns the fetch PC, drives instruction-memory address and buffers
// {instruction, PC+4} pairs in a small FIFO consumed by the decode stage.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLOCK_IN,
  input  logic                       RESET,
  output logic [31:0]                im_addr,
  input  logic [31:0]                im_data,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [31:0]                flush_target,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc_plus4,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [LW-1:0] r_count;

  logic          w_not_empty;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_pc_plus4;
  fq_entry_t     w_wr_entry;
  fq_entry_t     w_head;

  // Handshake: id_valid is the producer's valid, ~stall is the consumer's ready;
  // the head entry is consumed on every cycle where both are high. Ready may
  // depend on same-cycle valid, and a full queue accepts a push when it also pops.
  assign w_not_empty = (r_count != '0);
  assign w_pop       = w_not_empty & ~stall;
  assign w_push      = ~flush & ((r_count < LW'(DEPTH)) | w_pop);
  assign w_pc_plus4  = r_fetch_pc + 32'd4;

  assign w_wr_entry.instr    = im_data;
  assign w_wr_entry.pc_plus4 = w_pc_plus4;

  fq_storage #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .CLOCK_IN (CLOCK_IN),
    .i_we     (w_push),
    .i_waddr  (r_wr_ptr),
    .i_wdata  (w_wr_entry),
    .i_raddr  (r_rd_ptr),
    .o_rdata  (w_head)
  );

  // Reset beats flush, and flush beats push/pop/stall.
  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_fetch_pc <= word_align(flush_target);
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= w_pc_plus4;
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
    end
  end

  assign im_addr     = r_fetch_pc;
  assign id_valid    = w_not_empty;
  assign id_instr    = w_not_empty ? w_head.instr    : NOP_INSTR;
  assign id_pc_plus4 = w_not_empty ? w_head.pc_plus4 : 32'h0;
  assign level       = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (RESET_PC = 0) ----------------
  logic [31:0] im_addr, im_data, flush_target;
  logic        stall = 1'b0, flush = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc_plus4;
  logic [2:0]  level;
  logic [31:0] key = 32'h0;

  assign im_data = im_addr ^ key;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLOCK_IN     (clk),
    .RESET        (RESET),
    .im_addr      (im_addr),
    .im_data      (im_data),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .level        (level)
  );

  // ---------------- second DUT for PC wrap ----------------
  logic [31:0] w_im_addr, w_im_data;
  logic        w_stall = 1'b0, w_flush = 1'b0;
  logic [31:0] w_target = 32'h0;
  logic        w_id_valid;
  logic [31:0] w_id_instr, w_id_pc_plus4;
  logic [2:0]  w_level;

  assign w_im_data = w_im_addr;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .CLOCK_IN     (clk),
    .RESET        (RESET),
    .im_addr      (w_im_addr),
    .im_data      (w_im_data),
    .stall        (w_stall),
    .flush        (w_flush),
    .flush_target (w_target),
    .id_valid     (w_id_valid),
    .id_instr     (w_id_instr),
    .id_pc_plus4  (w_id_pc_plus4),
    .level        (w_level)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next state from the rules: reset > flush > pop/push.
  task automatic model_step(input logic rst, input logic stl, input logic fl,
                            input logic [31:0] tgt);
    logic pop, push;
    if (rst) begin
      exp_q.delete();
      m_pc = 32'h0;
    end else if (fl) begin
      exp_q.delete();
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      pop  = (exp_q.size() > 0) && !stl;
      push = (exp_q.size() < DEPTH) || pop;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({m_pc ^ key, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] ei, ep;
    ev = (exp_q.size() != 0);
    ei = ev ? exp_q[0][63:32] : 32'h0;
    ep = ev ? exp_q[0][31:0]  : 32'h0;
    chk("im_addr",     im_addr,           m_pc);
    chk("id_valid",    {31'b0, id_valid}, {31'b0, ev});
    chk("id_instr",    id_instr,          ei);
    chk("id_pc_plus4", id_pc_plus4,       ep);
    chk("level",       {29'b0, level},    exp_q.size());
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic rst, input logic stl, input logic fl,
                          input logic [31:0] tgt);
    RESET        = rst;
    stall        = stl;
    flush        = fl;
    flush_target = tgt;
    model_step(rst, stl, fl, tgt);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    flush_target = 32'h0;
    m_pc = 32'h0;

    // Reset / stream, with the wrap instance observed alongside.
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid",  {31'b0, id_valid}, 32'h0);
    chk("rst_level",  {29'b0, level},    32'h0);
    chk("rst_imaddr", im_addr,           32'h0);
    chk("wrap_pc0",   w_im_addr,         32'hFFFF_FFF8);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c1_instr",   id_instr,          32'h0);
    chk("c1_pc4",     id_pc_plus4,       32'h4);
    chk("c1_level",   {29'b0, level},    32'h1);
    chk("wrap_pc1",   w_im_addr,         32'hFFFF_FFFC);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("c2_instr",   id_instr,          32'h4);
    chk("c2_pc4",     id_pc_plus4,       32'h8);
    chk("c2_level",   {29'b0, level},    32'h1);
    chk("wrap_pc2",   w_im_addr,         32'h0);
    chk("wrap_pc4",   w_id_pc_plus4,     32'h0);
    chk("wrap_valid", {31'b0, w_id_valid}, 32'h1);

    // Fill to full under stall, then drain in order.
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("full_level",  {29'b0, level}, 32'h4);
    chk("full_imaddr", im_addr,        32'h10);
    chk("full_head",   id_instr,       32'h0);
    for (int k = 1; k <= 4; k++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("drain_head",  id_instr,       32'(4 * k));
      chk("drain_level", {29'b0, level}, 32'h4);
    end

    // Flush while full and stalled.
    do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b1, 1'b1, 32'h40);
    chk("fl_level",  {29'b0, level},    32'h0);
    chk("fl_valid",  {31'b0, id_valid}, 32'h0);
    chk("fl_imaddr", im_addr,           32'h40);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_instr",  id_instr,          32'h40);
    chk("fl_pc4",    id_pc_plus4,       32'h44);

    // Misaligned redirect.
    do_cycle(1'b0, 1'b0, 1'b1, 32'h47);
    chk("mis_imaddr", im_addr, 32'h44);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mis_instr",  id_instr, 32'h44);

    // Reset with level 3 and a concurrent flush.
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_level", {29'b0, level}, 32'h3);
    do_cycle(1'b1, 1'b0, 1'b1, 32'h80);
    chk("rf_level",  {29'b0, level},    32'h0);
    chk("rf_imaddr", im_addr,           32'h0);
    chk("rf_valid",  {31'b0, id_valid}, 32'h0);
    chk("rf_instr",  id_instr,          32'h0);
    chk("rf_pc4",    id_pc_plus4,       32'h0);

    // Randomized traffic.
    key = $urandom;
    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom_range(63) == 0), 1'($urandom_range(1)),
               ($urandom_range(15) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
